// File: rtl/spec_squash_buf_pkg.sv
// Shared defaults and slot layout for the speculative squash buffer.
package spec_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 4;
  localparam int unsigned DEF_ID_W   = 5;

  // Slot layout at the default widths; spec_entry re-declares it with its own parameters.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_ID_W-1:0]   id;
    logic                  valid;
    logic                  committed;
  } entry_t;

endpackage

// File: rtl/spec_squash_buf_entry.sv
// One buffer slot: payload storage plus the squash and commit ID compares.
module spec_entry
  import spec_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ID_W   = DEF_ID_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ID_W-1:0]   wr_id,
  input  logic              deq,
  input  logic              miss_valid,
  input  logic [ID_W-1:0]   miss_id,
  input  logic              commit_valid,
  input  logic [ID_W-1:0]   commit_id,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              committed,
  output logic              squash_c
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
    logic              valid;
    logic              committed;
  } slot_t;

  slot_t slot;
  logic  commit_hit;

  assign squash_c   = miss_valid && slot.valid && (slot.id >= miss_id);
  assign commit_hit = commit_valid && slot.valid && (slot.id <= commit_id);

  assign data      = slot.data;
  assign valid     = slot.valid;
  assign committed = slot.committed;

  // A write lands in the first free slot, so it beats a squash of the same slot; squash beats dequeue and commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
    end else if (wr) begin
      slot <= '{data: wr_data, id: wr_id, valid: 1'b1, committed: 1'b0};
    end else if (squash_c || deq) begin
      slot <= '0;
    end else if (commit_hit) begin
      slot.committed <= 1'b1;
    end
  end

endmodule

// File: rtl/spec_squash_buf.sv
// Circular buffer of speculative payloads; entries leave only once committed and vanish on misspeculation.
module spec_squash_buf
  import spec_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ID_W   = DEF_ID_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [ID_W-1:0]          in_id,
  output logic                     in_ready,
  input  logic                     miss_valid,
  input  logic [ID_W-1:0]          miss_id,
  input  logic                     commit_valid,
  input  logic [ID_W-1:0]          commit_id,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_order
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [ID_W-1:0]   last_id;

  logic [DATA_W-1:0] e_data [DEPTH];
  logic [DEPTH-1:0]  e_valid;
  logic [DEPTH-1:0]  e_committed;
  logic [DEPTH-1:0]  e_squash;
  logic [DEPTH-1:0]  e_wr;
  logic [DEPTH-1:0]  e_deq;

  logic [CW-1:0]     survivors;
  logic [ID_W-1:0]   miss_floor;
  logic [ID_W-1:0]   eff_last;
  logic [AW-1:0]     wr_ptr;
  logic              deq_fire;
  logic              enq_req;
  logic              enq_squashed;
  logic              order_bad;
  logic              enq_fire;
  logic              order_err;

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_slot
    spec_entry #(
      .DATA_W (DATA_W),
      .ID_W   (ID_W)
    ) u_entry (
      .clk          (clk),
      .rst          (rst),
      .wr           (e_wr[i]),
      .wr_data      (in_data),
      .wr_id        (in_id),
      .deq          (e_deq[i]),
      .miss_valid   (miss_valid),
      .miss_id      (miss_id),
      .commit_valid (commit_valid),
      .commit_id    (commit_id),
      .data         (e_data[i]),
      .valid        (e_valid[i]),
      .committed    (e_committed[i]),
      .squash_c     (e_squash[i])
    );
  end

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = e_valid[head] && e_committed[head];
  assign out_data  = out_valid ? e_data[head] : '0;

  // Entries that outlive this cycle's squash; IDs rise from head to tail so the squashed set is a tail suffix.
  always_comb begin
    survivors = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (e_valid[i] && !e_squash[i]) survivors = survivors + CW'(1);
    end
  end

  // A misspeculation rewinds the order tracker to just below miss_id so replayed IDs are legal again.
  always_comb begin
    miss_floor = (miss_id == '0) ? '0 : miss_id - ID_W'(1);
    eff_last   = last_id;
    if (miss_valid && (miss_floor < last_id)) eff_last = miss_floor;
  end

  // Enqueue/dequeue qualification and one-hot slot strobes.
  always_comb begin
    deq_fire     = out_valid && out_ready && !e_squash[head];
    enq_req      = in_valid && in_ready;
    enq_squashed = miss_valid && (in_id >= miss_id);
    order_bad    = (in_id < eff_last);
    enq_fire     = enq_req && !enq_squashed && !order_bad;
    order_err    = enq_req && !enq_squashed && order_bad;
    wr_ptr       = miss_valid ? (head + AW'(survivors)) : tail;
    e_wr         = enq_fire ? (DEPTH'(1) << wr_ptr) : '0;
    e_deq        = deq_fire ? (DEPTH'(1) << head) : '0;
  end

  // Pointer, occupancy and order-tracking state.
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      err_order <= 1'b0;
      last_id   <= '0;
    end else begin
      head      <= head + AW'(deq_fire);
      tail      <= wr_ptr + AW'(enq_fire);
      count     <= survivors - CW'(deq_fire) + CW'(enq_fire);
      err_order <= err_order | order_err;
      last_id   <= enq_fire ? in_id : eff_last;
    end
  end

endmodule

// File: tb/tb_spec_squash_buf.sv
// Randomised scoreboard bench for spec_squash_buf against a queue-based reference model.
module tb_spec_squash_buf;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int ID_W   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [ID_W-1:0]   in_id;
  logic              in_ready;
  logic              miss_valid;
  logic [ID_W-1:0]   miss_id;
  logic              commit_valid;
  logic [ID_W-1:0]   commit_id;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [$clog2(DEPTH):0] count;
  logic              err_order;

  spec_squash_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_id        (in_id),
    .in_ready     (in_ready),
    .miss_valid   (miss_valid),
    .miss_id      (miss_id),
    .commit_valid (commit_valid),
    .commit_id    (commit_id),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .count        (count),
    .err_order    (err_order)
  );

  always #5 clk = ~clk;

  typedef struct { int data; int id; bit committed; } ment_t;
  typedef struct { bit ov; int od; int cnt; bit rdy; bit err; } stat_t;

  ment_t mq[$];
  int    m_last;
  bit    m_err;
  stat_t stat_q[$];
  int    data_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  bit    done     = 0;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic idle();
    rst = 0; in_valid = 0; in_data = '0; in_id = '0;
    miss_valid = 0; miss_id = '0; commit_valid = 0; commit_id = '0; out_ready = 0;
  endtask

  // Record expected outputs for the current cycle, then advance the model across the clock edge.
  task automatic tick();
    stat_t s;
    ment_t keep[$];
    bit    deq;
    bit    enq_ok;
    int    floor_id;
    s.ov  = (mq.size() > 0) && mq[0].committed;
    s.od  = s.ov ? mq[0].data : 0;
    s.cnt = mq.size();
    s.rdy = (mq.size() < DEPTH);
    s.err = m_err;
    stat_q.push_back(s);
    if (s.ov && out_ready) data_q.push_back(mq[0].data);
    if (rst) begin
      mq.delete(); m_last = 0; m_err = 0;
    end else begin
      deq    = s.ov && out_ready;
      enq_ok = in_valid && s.rdy;
      if (miss_valid) begin
        if (s.ov && mq[0].id >= int'(miss_id)) deq = 0;
        keep = {};
        foreach (mq[i]) if (mq[i].id < int'(miss_id)) keep.push_back(mq[i]);
        mq = keep;
        floor_id = (miss_id == 0) ? 0 : int'(miss_id) - 1;
        if (floor_id < m_last) m_last = floor_id;
        if (int'(in_id) >= int'(miss_id)) enq_ok = 0;
      end
      if (commit_valid) foreach (mq[i]) if (mq[i].id <= int'(commit_id)) mq[i].committed = 1;
      if (deq) void'(mq.pop_front());
      if (enq_ok) begin
        if (int'(in_id) < m_last) m_err = 1;
        else begin
          mq.push_back('{int'(in_data), int'(in_id), 1'b0});
          m_last = int'(in_id);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic enq(int id, int data);
    idle(); in_valid = 1; in_id = ID_W'(id); in_data = DATA_W'(data); tick();
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); idle();
  endtask

  // Monitor: compares per-cycle status and pops the data scoreboard on every visible handshake.
  initial begin
    stat_t s;
    @(posedge clk);
    while (!done) begin
      @(negedge clk);
      if (done) break;
      if (stat_q.size() == 0) begin
        n_checks++;
        $display("FAIL stat_q: got empty expected entry at %0t", $time);
      end else begin
        s = stat_q.pop_front();
        check("out_valid", int'(out_valid), int'(s.ov));
        check("out_data",  int'(out_data),  s.od);
        check("count",     int'(count),     s.cnt);
        check("in_ready",  int'(in_ready),  int'(s.rdy));
        check("err_order", int'(err_order), int'(s.err));
      end
      if (out_valid && out_ready) begin
        if (data_q.size() == 0) begin
          n_checks++;
          $display("FAIL deq_data: got %0d expected no dequeue at %0t", out_data, $time);
        end else begin
          check("deq_data", int'(out_data), data_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int g;
    idle(); rst = 1;
    @(posedge clk); #1;
    m_last = 0; m_err = 0;
    idle();
    tick();

    // Commit a prefix and drain it.
    enq(1, 'hA1); enq(2, 'hA2); enq(3, 'hA3);
    idle(); commit_valid = 1; commit_id = 2; tick();
    idle(); out_ready = 1; tick(); tick(); tick();
    do_reset();

    // Fill, squash the younger half, refill the first erased slot.
    for (int i = 1; i <= 4; i++) enq(i, 'h10 + i);
    idle(); miss_valid = 1; miss_id = 3; tick();
    enq(3, 'h33);
    idle(); commit_valid = 1; commit_id = 31; tick();
    idle(); out_ready = 1; for (int i = 0; i < 4; i++) tick();
    do_reset();

    // Same-cycle miss with young and old enqueues.
    enq(1, 'h51);
    idle(); miss_valid = 1; miss_id = 2; in_valid = 1; in_id = 5; in_data = 'h55; tick();
    idle(); miss_valid = 1; miss_id = 2; in_valid = 1; in_id = 1; in_data = 'h52; tick();
    idle(); commit_valid = 1; commit_id = 1; out_ready = 1; tick(); tick(); tick();
    do_reset();

    // Out-of-order enqueue sets a sticky error.
    enq(6, 'h66); enq(4, 'h44);
    idle(); tick(); enq(7, 'h77); tick();
    do_reset();
    idle(); tick();

    // Full buffer streaming with everything committed; pointers wrap repeatedly.
    for (int i = 0; i < 4; i++) enq(8, 'h80 + i);
    for (int i = 0; i < 20; i++) begin
      idle(); in_valid = 1; in_id = 8; in_data = DATA_W'(i);
      commit_valid = 1; commit_id = 31; out_ready = 1; tick();
    end

    // Reset mid-stream while every other input is active.
    idle(); rst = 1; in_valid = 1; in_id = 9; miss_valid = 1; miss_id = 8;
    commit_valid = 1; commit_id = 9; out_ready = 1; tick();
    idle(); tick();

    // Random traffic with slowly rising IDs.
    g = 1;
    for (int c = 0; c < 1500; c++) begin
      idle();
      in_valid = ($urandom_range(0, 99) < 60);
      in_data  = DATA_W'($urandom);
      in_id    = ($urandom_range(0, 9) == 0) ? ID_W'((g > 3) ? g - 3 : 0) : ID_W'(g);
      if ($urandom_range(0, 2) == 0) g++;
      miss_valid   = ($urandom_range(0, 99) < 8);
      miss_id      = ID_W'((g > 3) ? g - int'($urandom_range(0, 3)) : g);
      commit_valid = ($urandom_range(0, 99) < 40);
      commit_id    = ID_W'((g > 4) ? g - int'($urandom_range(0, 4)) : g);
      out_ready    = ($urandom_range(0, 99) < 70);
      rst          = ($urandom_range(0, 199) == 0) || (g >= 30);
      tick();
      if (rst) g = 0;
    end
    idle(); tick();
    done = 1;
    @(posedge clk); #1;
    n_checks++;
    if (stat_q.size() == 0 && data_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d/%0d leftover expected 0/0", stat_q.size(), data_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spec_squash_buf.md
SPEC_SQUASH_BUF -- requirements
Module: spec_squash_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of entries; legal values are powers of two, 2..16.
REQ-003 SHALL have parameter ID_W, default 5, speculation-ID width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  enqueue request.
REQ-007 SHALL have port in_data  input  DATA_W  enqueue payload.
REQ-008 SHALL have port in_id  input  ID_W  speculation ID of payload.
REQ-009 SHALL have port in_ready  output  1  high when count < DEPTH.
REQ-010 SHALL have port miss_valid  input  1  misspeculation event.
REQ-011 SHALL have port miss_id  input  ID_W  oldest mispredicted ID.
REQ-012 SHALL have port commit_valid  input  1  commit event.
REQ-013 SHALL have port commit_id  input  ID_W  youngest committed ID.
REQ-014 SHALL have port out_valid  output  1  head entry valid and committed.
REQ-015 SHALL have port out_data  output  DATA_W  head payload, zero when out_valid low.
REQ-016 SHALL have port out_ready  input  1  dequeue accept.
REQ-017 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.
REQ-018 SHALL have port err_order  output  1  sticky: out-of-order enqueue ID seen.

Function
REQ-019 Each entry SHALL hold data, id, valid, committed; circular FIFO, head/tail pointers wrap modulo DEPTH.
REQ-020 Enqueue SHALL occur when in_valid && in_ready; entry visible at head/count next cycle; committed clears on enqueue.
REQ-021 IDs SHALL compare unsigned, no wrap; enqueue with in_id < last accepted in_id SHALL be dropped and set err_order.
REQ-022 On miss_valid, every valid entry with id >= miss_id SHALL be erased next cycle: valid=0, data=0, committed=0; tail retracts to first erased slot; count updates accordingly.
REQ-023 On commit_valid, every valid entry with id <= commit_id SHALL set committed next cycle.
REQ-024 Dequeue SHALL occur when out_valid && out_ready; head entry data zeroed, valid cleared, head advances.
REQ-025 out_valid/out_data SHALL be combinational from head entry; uncommitted head SHALL never drive data (out_data=0).
REQ-026 Same-cycle miss and enqueue: enqueue with in_id >= miss_id SHALL be dropped (no err_order); else accepted after squash tail.
REQ-027 Same-cycle miss and commit covering same entry: squash SHALL win.
REQ-028 Same-cycle dequeue and squash of head: squash wins, no dequeue counted.
REQ-029 in_ready SHALL depend only on registered count (full stays not-ready even if dequeue same cycle).
REQ-030 Dequeue with empty buffer or uncommitted head SHALL have no effect.

Reset
REQ-031 On rst: all entries data=0, valid=0, committed=0; head=tail=0; count=0; err_order=0; last-ID tracker=0; out_valid=0, out_data=0, in_ready=1.
REQ-032 rst SHALL override all same-cycle enqueue/miss/commit/dequeue.

Structure
REQ-033 Package spec_pkg SHALL hold default DATA_W/DEPTH/ID_W constants and parametrised entry struct typedef (data, id, valid, committed).
REQ-034 Sub-module spec_entry SHALL implement one slot: storage plus squash (id >= miss_id) and commit (id <= commit_id) compare; instantiated DEPTH times.

Verification
REQ-035 Enqueue ids 1,2,3 data A1,A2,A3; commit_id=2 -> out_valid, dequeues A1,A2; head id3 gives out_valid=0, out_data=0.
REQ-036 Fill 4 entries ids 1..4; miss_id=3 -> count 4->2, in_ready=1, erased slots data=0; next enqueue id 3 lands at slot 2.
REQ-037 Same cycle miss_id=2 and enqueue id 5 -> enqueue dropped, err_order=0; enqueue id 1 same cycle with miss_id=2 -> accepted.
REQ-038 Enqueue id 6 then id 4 -> id 4 dropped, err_order=1 and stays 1 until rst.
REQ-039 Full buffer, commit all, out_ready=1 every cycle, in_valid=1 -> pointers wrap twice, data order preserved, in_ready low in full cycles.
REQ-040 Assert rst mid-stream with miss/commit/enqueue active -> all outputs at reset values next cycle.
